// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with blank interval and double-buffered digit data.
// Optional leading-zero blanking is compiled in when SEVEN_SEG_LZB_EN is defined.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   addr,
  output logic [7:0]              out,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [PW-1:0]                pre_cnt_q, pre_cnt_d;
  logic [DW-1:0]                dig_idx_q, dig_idx_d;
  logic [NUM_DIGITS-1:0][3:0]   stg_data_q, stg_data_d;
  logic [NUM_DIGITS-1:0]        stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0]        stg_blank_q, stg_blank_d;
  logic                         pending_q, pending_d;
  logic [NUM_DIGITS-1:0][3:0]   shd_data_q, shd_data_d;
  logic [NUM_DIGITS-1:0]        shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0]        shd_blank_q, shd_blank_d;
  logic [NUM_DIGITS-1:0]        addr_q, addr_d;
  logic [7:0]                   out_q, out_d;
  logic                         frame_done_q, frame_done_d;

  logic                         slot_end_s;
  logic                         boundary_s;
  logic [7:0]                   seg_s;
  logic [NUM_DIGITS-1:0]        one_hot_s;

  assign slot_end_s = (pre_cnt_q == PRE_LAST);
  assign boundary_s = slot_end_s && (dig_idx_q == DIG_LAST);
  assign one_hot_s  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << dig_idx_q;

  // Scan counters and the staging/shadow double buffer.
  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    dig_idx_d   = dig_idx_q;
    stg_data_d  = stg_data_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    pending_d   = pending_q;
    shd_data_d  = shd_data_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;

    if (slot_end_s) begin
      pre_cnt_d = {PW{1'b0}};
      if (dig_idx_q == DIG_LAST) begin
        dig_idx_d = {DW{1'b0}};
      end else begin
        dig_idx_d = dig_idx_q + DW'(1);
      end
    end else begin
      pre_cnt_d = pre_cnt_q + PW'(1);
    end

    if (load) begin
      stg_data_d  = data_in;
      stg_dp_d    = dp_in;
      stg_blank_d = blank_in;
    end else begin
      stg_data_d  = stg_data_q;
    end

    // A load landing on the boundary bypasses staging so it is never deferred a frame.
    if (boundary_s) begin
      pending_d = 1'b0;
      if (load) begin
        shd_data_d  = data_in;
        shd_dp_d    = dp_in;
        shd_blank_d = blank_in;
      end else if (pending_q) begin
        shd_data_d  = stg_data_q;
        shd_dp_d    = stg_dp_q;
        shd_blank_d = stg_blank_q;
      end else begin
        shd_data_d  = shd_data_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Segment and digit-enable generation from the current slot and shadow data.
  always_comb begin
    logic lz_s;
    lz_s  = 1'b1;
    seg_s = {shd_dp_q[dig_idx_q], seg_decode(shd_data_q[dig_idx_q])};
`ifdef SEVEN_SEG_LZB_EN
    for (int j = 0; j < NUM_DIGITS; j++) begin
      lz_s = lz_s & ~((DW'(j) >= dig_idx_q) & (shd_data_q[j] != 4'h0));
    end
    if (lz_s && (dig_idx_q != {DW{1'b0}})) begin
      seg_s = {shd_dp_q[dig_idx_q], 7'h00};
    end else begin
      seg_s = {shd_dp_q[dig_idx_q], seg_decode(shd_data_q[dig_idx_q])};
    end
`else
    lz_s = 1'b0;
`endif

    frame_done_d = boundary_s;
    if (pre_cnt_q < BLANK_END) begin
      addr_d = {NUM_DIGITS{1'b1}};
      out_d  = 8'hFF;
    end else begin
      addr_d = ~one_hot_s;
      if (shd_blank_q[dig_idx_q]) begin
        out_d = 8'hFF;
      end else begin
        out_d = ~seg_s;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q    <= {PW{1'b0}};
      dig_idx_q    <= {DW{1'b0}};
      stg_data_q   <= {(4*NUM_DIGITS){1'b0}};
      stg_dp_q     <= {NUM_DIGITS{1'b0}};
      stg_blank_q  <= {NUM_DIGITS{1'b0}};
      pending_q    <= 1'b0;
      shd_data_q   <= {(4*NUM_DIGITS){1'b0}};
      shd_dp_q     <= {NUM_DIGITS{1'b0}};
      shd_blank_q  <= {NUM_DIGITS{1'b0}};
      addr_q       <= {NUM_DIGITS{1'b1}};
      out_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      dig_idx_q    <= dig_idx_d;
      stg_data_q   <= stg_data_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      pending_q    <= pending_d;
      shd_data_q   <= shd_data_d;
      shd_dp_q     <= shd_dp_d;
      shd_blank_q  <= shd_blank_d;
      addr_q       <= addr_d;
      out_q        <= out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign addr       = addr_q;
  assign out        = out_q;
  assign frame_done = frame_done_q;

endmodule
